// File: rtl/axis_bram_adapter.sv
// AXI-Stream <-> wide single-port BRAM adapter: packs slave beats into BRAM words (write mode)
// or serialises BRAM words into master beats (read mode) over an inclusive address range.
module axis_bram_adapter #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_BRAM_DATA_WIDTH  = 1152,
    parameter int unsigned C_BRAM_ADDR_WIDTH  = 12
) (
    input  logic                            s00_axis_aclk,
    input  logic                            s00_axis_areset,

    output logic                            BRAM_CLK,
    output logic                            BRAM_EN,
    output logic                            BRAM_WEN,
    output logic [C_BRAM_ADDR_WIDTH-1:0]    BRAM_ADDR,
    output logic [C_BRAM_DATA_WIDTH-1:0]    BRAM_IN,
    input  logic [C_BRAM_DATA_WIDTH-1:0]    BRAM_OUT,

    output logic                            s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                            s00_axis_tlast,
    input  logic                            s00_axis_tvalid,

    output logic                            m00_axis_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tlast,
    input  logic                            m00_axis_tready,

    input  logic                            rw,
    input  logic                            addr_reload,
    input  logic [C_BRAM_ADDR_WIDTH-1:0]    bram_start_addr,
    input  logic [C_BRAM_ADDR_WIDTH-1:0]    bram_bound_addr
);

    localparam int unsigned TW    = C_AXIS_TDATA_WIDTH;
    localparam int unsigned BW    = C_BRAM_DATA_WIDTH;
    localparam int unsigned AW    = C_BRAM_ADDR_WIDTH;
    localparam int unsigned BEATS = BW / TW;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_SEND
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    bound;
    logic [CNT_W-1:0] cnt;
    logic [BW-TW-1:0] wbuf;
    logic [BW-1:0]    rbuf;
    logic [BW-1:0]    bram_in_q;
    logic             wr_fire;
    logic [AW-1:0]    wr_addr;

    logic s_hs;
    logic m_hs;
    logic last_beat;
    logic at_bound;

    // Slave tstrb/tlast carry no control meaning here; termination is by address bound only.
    logic unused_sideband;
    assign unused_sideband = ^{s00_axis_tstrb, s00_axis_tlast};

    assign BRAM_CLK  = s00_axis_aclk;
    assign BRAM_IN   = bram_in_q;
    assign s_hs      = s00_axis_tvalid && s00_axis_tready;
    assign m_hs      = m00_axis_tvalid && m00_axis_tready;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign at_bound  = (addr == bound);

    always_comb begin
        state_nxt       = state;
        s00_axis_tready = 1'b0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tlast  = 1'b0;
        BRAM_EN         = 1'b0;
        BRAM_WEN        = 1'b0;
        BRAM_ADDR       = '0;

        if (addr_reload) begin
            state_nxt = rw ? S_WR : S_RD_ISSUE;
        end else begin
            unique case (state)
                S_IDLE:     state_nxt = S_IDLE;
                S_WR:       if (s_hs && last_beat && at_bound) state_nxt = S_IDLE;
                S_RD_ISSUE: state_nxt = S_RD_WAIT;
                S_RD_WAIT:  state_nxt = S_RD_SEND;
                S_RD_SEND:  if (m_hs && last_beat) state_nxt = at_bound ? S_IDLE : S_RD_ISSUE;
                default:    state_nxt = S_IDLE;
            endcase
        end

        s00_axis_tready = (state == S_WR);

        if (state == S_RD_SEND) begin
            m00_axis_tvalid = 1'b1;
            m00_axis_tdata  = rbuf[TW-1:0];
            m00_axis_tstrb  = '1;
            m00_axis_tlast  = last_beat && at_bound;
        end

        // A packed word is written the cycle after its final beat; this never overlaps a read issue.
        if (wr_fire) begin
            BRAM_EN   = 1'b1;
            BRAM_WEN  = 1'b1;
            BRAM_ADDR = wr_addr;
        end else if (state == S_RD_ISSUE) begin
            BRAM_EN   = 1'b1;
            BRAM_ADDR = addr;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state     <= S_IDLE;
            addr      <= '0;
            bound     <= '0;
            cnt       <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
            bram_in_q <= '0;
            wr_fire   <= 1'b0;
            wr_addr   <= '0;
        end else begin
            state   <= state_nxt;
            wr_fire <= 1'b0;

            if (addr_reload) begin
                addr  <= bram_start_addr;
                bound <= bram_bound_addr;
                cnt   <= '0;
            end else begin
                unique case (state)
                    S_WR: begin
                        if (s_hs) begin
                            // Shift in from the top so the first beat ends up in the LSBs.
                            wbuf <= {s00_axis_tdata, wbuf[BW-TW-1:TW]};
                            if (last_beat) begin
                                bram_in_q <= {s00_axis_tdata, wbuf};
                                wr_fire   <= 1'b1;
                                wr_addr   <= addr;
                                cnt       <= '0;
                                if (!at_bound) addr <= addr + 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    S_RD_WAIT: begin
                        rbuf <= BRAM_OUT;
                        cnt  <= '0;
                    end
                    S_RD_SEND: begin
                        if (m_hs) begin
                            rbuf <= {{TW{1'b0}}, rbuf[BW-1:TW]};
                            if (last_beat) begin
                                cnt <= '0;
                                if (!at_bound) addr <= addr + 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_bram_adapter.sv
// Scoreboard bench for axis_bram_adapter: directed transfers queue expected BRAM writes,
// read issues and master beats; a negedge monitor pops and compares as the DUT presents them.
module tb_axis_bram_adapter;

    localparam int TW    = 32;
    localparam int BW    = 1152;
    localparam int AW    = 12;
    localparam int BEATS = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          bram_clk;
    logic          bram_en;
    logic          bram_wen;
    logic [AW-1:0] bram_addr;
    logic [BW-1:0] bram_in;
    logic [BW-1:0] bram_out = '0;
    logic          s_tready;
    logic [TW-1:0] s_tdata;
    logic [3:0]    s_tstrb;
    logic          s_tlast;
    logic          s_tvalid;
    logic          m_tvalid;
    logic [TW-1:0] m_tdata;
    logic [3:0]    m_tstrb;
    logic          m_tlast;
    logic          m_tready;
    logic          rw;
    logic          addr_reload;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] bound_addr;

    always #5 clk = ~clk;

    axis_bram_adapter #(
        .C_AXIS_TDATA_WIDTH (TW),
        .C_BRAM_DATA_WIDTH  (BW),
        .C_BRAM_ADDR_WIDTH  (AW)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .BRAM_CLK        (bram_clk),
        .BRAM_EN         (bram_en),
        .BRAM_WEN        (bram_wen),
        .BRAM_ADDR       (bram_addr),
        .BRAM_IN         (bram_in),
        .BRAM_OUT        (bram_out),
        .s00_axis_tready (s_tready),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tvalid (s_tvalid),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready),
        .rw              (rw),
        .addr_reload     (addr_reload),
        .bram_start_addr (start_addr),
        .bram_bound_addr (bound_addr)
    );

    // Single-port BRAM model, 1-cycle read latency.
    logic [BW-1:0] mem [int];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_wen) mem[int'(bram_addr)] = bram_in;
            else bram_out <= mem.exists(int'(bram_addr)) ? mem[int'(bram_addr)] : '0;
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } wr_exp_t;
    typedef struct {
        logic [TW-1:0] data;
        logic          last;
    } beat_t;

    wr_exp_t       wr_q[$];
    logic [AW-1:0] rd_q[$];
    beat_t         beat_q[$];

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_word(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else begin
            for (int i = 0; i < BEATS; i++) begin
                if (act[32*i +: 32] !== exp[32*i +: 32]) begin
                    $display("FAIL %s: beat %0d got %h expected %h", name, i,
                             act[32*i +: 32], exp[32*i +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        check_cnt++;
        $display("FAIL %s: got event with value %h expected none", name, act);
    endtask

    // Monitor: samples on the falling edge, between active edges.
    logic          stalled_prev = 1'b0;
    logic [TW-1:0] held_data    = '0;
    logic          held_last    = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_en && bram_wen) begin
                if (wr_q.size() == 0) unexpected("spurious_write", 64'(bram_addr));
                else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    chk("write_addr", 64'(bram_addr), 64'(e.addr));
                    chk_word("write_data", bram_in, e.data);
                end
            end
            if (bram_en && !bram_wen) begin
                if (rd_q.size() == 0) unexpected("spurious_read", 64'(bram_addr));
                else chk("read_addr", 64'(bram_addr), 64'(rd_q.pop_front()));
            end
            if (m_tvalid && stalled_prev) begin
                chk("stall_data_stable", 64'(m_tdata), 64'(held_data));
                chk("stall_last_stable", 64'(m_tlast), 64'(held_last));
            end
            if (m_tvalid && m_tready) begin
                if (beat_q.size() == 0) unexpected("spurious_beat", 64'(m_tdata));
                else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_data", 64'(m_tdata), 64'(b.data));
                    chk("beat_last", 64'(m_tlast), 64'(b.last));
                    chk("beat_strb", 64'(m_tstrb), 64'h0000_0000_0000_000F);
                end
            end
            stalled_prev = m_tvalid && !m_tready;
            held_data    = m_tdata;
            held_last    = m_tlast;
        end
    end

    task automatic pulse_reload(input logic mode, input logic [AW-1:0] st, input logic [AW-1:0] bd);
        @(posedge clk); #1;
        rw          = mode;
        start_addr  = st;
        bound_addr  = bd;
        addr_reload = 1'b1;
        @(posedge clk); #1;
        addr_reload = 1'b0;
    endtask

    task automatic send_beat(input logic [TW-1:0] d);
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk); #1;
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check_cnt++;
            $display("FAIL send_timeout: got tready low for 50 cycles expected acceptance of %h", d);
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            if (wr_q.size() == 0 && rd_q.size() == 0 && beat_q.size() == 0) break;
        end
        repeat (4) @(posedge clk);
        chk(name, 64'(wr_q.size() + rd_q.size() + beat_q.size()), 64'd0);
        wr_q.delete();
        rd_q.delete();
        beat_q.delete();
    endtask

    task automatic push_beats(input logic [BW-1:0] w0, input logic [BW-1:0] w1);
        for (int i = 0; i < 2 * BEATS; i++) begin
            beat_t b;
            b.data = (i < BEATS) ? w0[32*i +: 32] : w1[32*(i-BEATS) +: 32];
            b.last = (i == 2 * BEATS - 1);
            beat_q.push_back(b);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_exp_t       e;
        logic [BW-1:0] w0;
        logic [BW-1:0] w1;

        rst = 1'b1; s_tdata = '0; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b0;
        m_tready = 1'b0; rw = 1'b0; addr_reload = 1'b0; start_addr = '0; bound_addr = '0;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bram_en", 64'(bram_en), 64'd0);
        chk("rst_bram_wen", 64'(bram_wen), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr), 64'd0);
        chk_word("rst_bram_in", bram_in, '0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tstrb", 64'(m_tstrb), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 2: two-word write, constant tvalid
        e.addr = 12'd3; e.data = {18{32'hFFFF_FFFF, 32'h0000_0000}}; wr_q.push_back(e);
        e.addr = 12'd4; e.data = {18{32'hCCCC_CCCC, 32'hAAAA_AAAA}}; wr_q.push_back(e);
        pulse_reload(1'b1, 12'd3, 12'd4);
        for (int i = 0; i < 2 * BEATS; i++) begin
            if (i < BEATS) send_beat((i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0000_0000);
            else           send_beat((i % 2 == 1) ? 32'hCCCC_CCCC : 32'hAAAA_AAAA);
        end
        s_tvalid = 1'b0;
        chk("wr_tready_drop", 64'(s_tready), 64'd0);
        drain("drain_write_3_4", 200);

        // 3: two-word read, tready held high
        mem[6] = {18{32'hCCCC_CCCC, 32'hAAAA_AAAA}};
        mem[7] = {18{32'hCCCC_CCCC, 32'hAAAA_AAAA}};
        rd_q.push_back(12'd6);
        rd_q.push_back(12'd7);
        push_beats(mem[6], mem[7]);
        m_tready = 1'b1;
        pulse_reload(1'b0, 12'd6, 12'd7);
        drain("drain_read_6_7", 400);
        chk("rd_idle_tvalid", 64'(m_tvalid), 64'd0);

        // 4: read with tready toggling every cycle
        mem[20] = {18{32'h2222_2222, 32'h1111_1111}};
        mem[21] = {18{32'h4444_4444, 32'h3333_3333}};
        rd_q.push_back(12'd20);
        rd_q.push_back(12'd21);
        push_beats(mem[20], mem[21]);
        m_tready = 1'b0;
        pulse_reload(1'b0, 12'd20, 12'd21);
        for (int n = 0; n < 800; n++) begin
            @(posedge clk); #1;
            m_tready = ~m_tready;
            if (beat_q.size() == 0) break;
        end
        m_tready = 1'b1;
        drain("drain_read_toggle", 50);

        // 5: partial word with tvalid gaps, aborted by reload, then one full word
        for (int i = 0; i < BEATS; i++) w0[32*i +: 32] = 32'h5000_0000 + 32'(i);
        e.addr = 12'd10; e.data = w0; wr_q.push_back(e);
        pulse_reload(1'b1, 12'd10, 12'd10);
        for (int i = 0; i < 20; i++) begin
            send_beat(32'hDEAD_0000 + 32'(i));
            s_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        pulse_reload(1'b1, 12'd10, 12'd10);
        for (int i = 0; i < BEATS; i++) send_beat(32'h5000_0000 + 32'(i));
        s_tvalid = 1'b0;
        chk("abort_tready_drop", 64'(s_tready), 64'd0);
        drain("drain_abort", 200);

        // 6: wrap 4095 -> 0
        for (int i = 0; i < BEATS; i++) begin
            w0[32*i +: 32] = 32'h6000_0000 + 32'(i);
            w1[32*i +: 32] = 32'h6000_0000 + 32'(i + BEATS);
        end
        e.addr = 12'd4095; e.data = w0; wr_q.push_back(e);
        e.addr = 12'd0;    e.data = w1; wr_q.push_back(e);
        pulse_reload(1'b1, 12'd4095, 12'd0);
        for (int i = 0; i < 2 * BEATS; i++) send_beat(32'h6000_0000 + 32'(i));
        s_tvalid = 1'b0;
        chk("wrap_tready_drop", 64'(s_tready), 64'd0);
        drain("drain_wrap", 200);
        @(negedge clk);
        chk("wrap_idle_tready", 64'(s_tready), 64'd0);
        chk("wrap_idle_en", 64'(bram_en), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
